// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for an async FIFO.
// Issues credit-qualified read strobes, absorbs the fixed memory read latency
// in a small circular buffer, and presents the words as a valid/ready stream.
// Optional build macro FIFO_RD_STARVE_CNT_EN adds a saturating 16-bit
// starve_cnt output (cycles where m_ready=1 and m_valid=0).
module fifo_rd_stream #(
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 1,
  localparam int BUF_DEPTH = RD_LAT + 1
) (
  input  logic                         rd_clk,
  input  logic                         rest,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic [DWIDTH-1:0]            fifo_rd_data,
  input  logic                         flush,
  output logic                         m_valid,
  output logic [DWIDTH-1:0]            m_data,
  input  logic                         m_ready,
  output logic [$clog2(BUF_DEPTH):0]   buf_level
`ifdef FIFO_RD_STARVE_CNT_EN
  ,
  output logic [15:0]                  starve_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);  // buffer index width
  localparam int LW = PW + 1;             // level width
  localparam int SW = LW + 2;             // headroom for credit arithmetic

  logic [PW:0]       wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [DWIDTH-1:0] mem_r [BUF_DEPTH];
  logic [RD_LAT-1:0] infl_r, infl_nxt_s;
  logic [LW-1:0]     level_r, level_nxt_s;
  logic [DWIDTH-1:0] data_r, data_nxt_s;
  logic [SW-1:0]     infl_cnt_s;
  logic              buf_empty_s, pop_s, wr_s, credit_ok_s;

  // Advance a {wrap, index} pointer; index wraps at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
    logic [PW:0] r;
    if (p[PW-1:0] == PW'(BUF_DEPTH - 1)) begin
      r = {~p[PW], {PW{1'b0}}};
    end else begin
      r = p + {{PW{1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Equal index and equal wrap bit means empty; differing wrap bits would mean full.
  assign buf_empty_s = (wr_ptr_r == rd_ptr_r);
  assign m_valid     = ~buf_empty_s;
  assign pop_s       = m_valid & m_ready;
  assign m_data      = data_r;
  assign buf_level   = level_r;
  // The oldest tag leaving the shift register marks fifo_rd_data as valid now.
  assign wr_s        = infl_r[RD_LAT-1] & ~flush;
  assign fifo_rd_en  = ~fifo_empty & ~flush & ~rest & credit_ok_s;

  // Credit: buffered words plus reads in flight, less this cycle's pop, must leave a free slot.
  always_comb begin
    infl_cnt_s = {SW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      infl_cnt_s = infl_cnt_s + SW'(infl_r[i]);
    end
    credit_ok_s = ((SW'(level_r) + infl_cnt_s) < (SW'(BUF_DEPTH) + SW'(pop_s)));
  end

  // Next-state for pointers, level and the in-flight tags; flush wipes all of it.
  always_comb begin
    infl_nxt_s   = {RD_LAT{1'b0}};
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    if (flush) begin
      wr_ptr_nxt_s = {(PW+1){1'b0}};
      rd_ptr_nxt_s = {(PW+1){1'b0}};
      level_nxt_s  = {LW{1'b0}};
    end else begin
      infl_nxt_s[0] = fifo_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        infl_nxt_s[i] = infl_r[i-1];
      end
      if (wr_s) begin
        wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      level_nxt_s = level_r + LW'(wr_s) - LW'(pop_s);
    end
  end

  // Next head word for the registered m_data; bypass when the head is the slot being written.
  always_comb begin
    data_nxt_s = data_r;
    if (!flush && (wr_ptr_nxt_s != rd_ptr_nxt_s)) begin
      if (wr_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
        data_nxt_s = fifo_rd_data;
      end else begin
        data_nxt_s = mem_r[rd_ptr_nxt_s[PW-1:0]];
      end
    end else begin
      data_nxt_s = data_r;
    end
  end

  // State registers: buffer storage, pointers, level, in-flight tags and output data.
  always_ff @(posedge rd_clk or posedge rest) begin
    if (rest) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      level_r  <= {LW{1'b0}};
      infl_r   <= {RD_LAT{1'b0}};
      data_r   <= {DWIDTH{1'b0}};
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= {DWIDTH{1'b0}};
      end
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      infl_r   <= infl_nxt_s;
      data_r   <= data_nxt_s;
      if (wr_s) begin
        mem_r[wr_ptr_r[PW-1:0]] <= fifo_rd_data;
      end
    end
  end

`ifdef FIFO_RD_STARVE_CNT_EN
  logic [15:0] starve_cnt_r;
  assign starve_cnt = starve_cnt_r;

  // Count cycles where downstream is ready but nothing is offered; saturates.
  always_ff @(posedge rd_clk or posedge rest) begin
    if (rest) begin
      starve_cnt_r <= 16'h0000;
    end else if (flush) begin
      starve_cnt_r <= 16'h0000;
    end else if (m_ready && !m_valid && (starve_cnt_r != 16'hFFFF)) begin
      starve_cnt_r <= starve_cnt_r + 16'h0001;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

endmodule
